regfile_wb_scheduler: RTL and testbench

- Sits between the pipeline issue/writeback stages and the 32x32 register file.
- Drives the register file's write port C. Arbitrates that single port between single-cycle ALU results and variable-latency load returns.
- Keeps a scoreboard of registers with outstanding loads and stalls issue on RAW/WAW hazards against them.
- Tracks outstanding load destinations in order, in a small FIFO.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wb_scheduler_if.sv | 61 ++++++
 rtl/wb_dest_fifo.sv | 58 +++++
 rtl/regfile_wb_scheduler.sv | 126 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback scheduler slice.
package regfile_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam int        NUM_REGS = 32;

    // One-hot register mask; register 0 never appears in any mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (a != REG_ZERO) v[a] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue / ALU-writeback / load-return / write-port C bundle for the scheduler.
// The fwd_* mirror of the write port exists only when WB_LOAD_BYPASS_EN is defined.
interface regfile_wb_scheduler_if #(
    parameter int MAX_LOADS = 4
) ();
    import regfile_pkg::*;

    localparam int CNT_W = $clog2(MAX_LOADS) + 1;

    logic             issue_valid;
    reg_addr_t        issue_rs;
    reg_addr_t        issue_rt;
    reg_addr_t        issue_dest;
    logic             issue_is_load;
    logic             issue_stall;

    logic             alu_wb_valid;
    reg_addr_t        alu_wb_addr;
    reg_data_t        alu_wb_data;
    logic             alu_hold;

    logic             ld_valid;
    reg_data_t        ld_data;
    logic             ld_ready;

    reg_addr_t        wr_addr_c;
    logic             wr_enable_c;
    reg_data_t        wr_data_c;
    logic [CNT_W-1:0] loads_pending;

`ifdef WB_LOAD_BYPASS_EN
    logic             fwd_valid;
    reg_addr_t        fwd_addr;
    reg_data_t        fwd_data;
`endif

    // Pipeline side: presents requests, observes grants and the write port.
    modport master (
        output issue_valid, issue_rs, issue_rt, issue_dest, issue_is_load,
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output ld_valid, ld_data,
        input  issue_stall, alu_hold, ld_ready,
        input  wr_addr_c, wr_enable_c, wr_data_c, loads_pending
`ifdef WB_LOAD_BYPASS_EN
        , input fwd_valid, fwd_addr, fwd_data
`endif
    );

    // Scheduler side.
    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_dest, issue_is_load,
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  ld_valid, ld_data,
        output issue_stall, alu_hold, ld_ready,
        output wr_addr_c, wr_enable_c, wr_data_c, loads_pending
`ifdef WB_LOAD_BYPASS_EN
        , output fwd_valid, fwd_addr, fwd_data
`endif
    );

endinterface

// File: rtl/wb_dest_fifo.sv
// In-order FIFO of outstanding load destination registers.
// Pop is only honoured when non-empty, so a push into an empty FIFO is never
// visible at the head in the same cycle. A push while full is accepted only
// when a pop frees a slot in the same cycle.
module wb_dest_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  reg_addr_t              i_push_data,
    input  logic                   i_pop,
    output reg_addr_t              o_pop_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    reg_addr_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port C arbiter between ALU results and in-order load returns, with a
// pending-load scoreboard that stalls issue on RAW/WAW hazards.
// Optional macro WB_LOAD_BYPASS_EN: the returning load's register is treated
// as already written for hazard checks, a same-cycle pop frees a FIFO slot for
// a new load, and the write port is mirrored on fwd_*.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int MAX_LOADS    = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LOADS) + 1;
    localparam int SW    = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic                w_fifo_push;
    logic                w_fifo_pop;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    reg_addr_t           w_head;
    logic [CNT_W-1:0]    w_fifo_count;

    logic [SW-1:0]       r_starve_cnt;
    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [NUM_REGS-1:0] w_haz_mask;

    logic                w_ld_avail;
    logic                w_load_win;
    logic                w_full_eff;
    logic                w_hazard;

    wb_dest_fifo #(.DEPTH(MAX_LOADS)) u_dest_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_fifo_push),
        .i_push_data (bus.issue_dest),
        .i_pop       (w_fifo_pop),
        .o_pop_data  (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // A load return with nothing outstanding is never granted.
    assign w_ld_avail = bus.ld_valid && !w_fifo_empty;
    assign w_load_win = !reset && w_ld_avail &&
                        (!bus.alu_wb_valid || (r_starve_cnt == STARVE_MAX));
    assign w_fifo_pop = w_load_win;

`ifdef WB_LOAD_BYPASS_EN
    assign w_haz_mask = r_pending & ~(w_load_win ? reg_onehot(w_head) : '0);
    assign w_full_eff = w_fifo_full && !w_fifo_pop;
`else
    assign w_haz_mask = r_pending;
    assign w_full_eff = w_fifo_full;
`endif

    assign w_hazard = w_haz_mask[bus.issue_rs] || w_haz_mask[bus.issue_rt] ||
                      ((bus.issue_dest != REG_ZERO) && w_haz_mask[bus.issue_dest]) ||
                      (bus.issue_is_load && w_full_eff);

    assign bus.issue_stall   = !reset && bus.issue_valid && w_hazard;
    assign w_fifo_push       = !reset && bus.issue_valid && bus.issue_is_load && !w_hazard;
    assign bus.loads_pending = reset ? '0 : w_fifo_count;

    // Write-port C mux: the winning request drives the register file directly.
    always_comb begin
        bus.wr_addr_c   = REG_ZERO;
        bus.wr_data_c   = '0;
        bus.wr_enable_c = 1'b0;
        bus.ld_ready    = 1'b0;
        bus.alu_hold    = 1'b0;
        if (w_load_win) begin
            bus.wr_addr_c   = w_head;
            bus.wr_data_c   = bus.ld_data;
            bus.wr_enable_c = (w_head != REG_ZERO);
            bus.ld_ready    = 1'b1;
            bus.alu_hold    = bus.alu_wb_valid;
        end else if (!reset && bus.alu_wb_valid) begin
            bus.wr_addr_c   = bus.alu_wb_addr;
            bus.wr_data_c   = bus.alu_wb_data;
            bus.wr_enable_c = (bus.alu_wb_addr != REG_ZERO);
        end
    end

`ifdef WB_LOAD_BYPASS_EN
    assign bus.fwd_valid = bus.wr_enable_c;
    assign bus.fwd_addr  = bus.wr_addr_c;
    assign bus.fwd_data  = bus.wr_data_c;
`endif

    // Starvation counter: counts refused load returns, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_load_win) begin
            r_starve_cnt <= '0;
        end else if (w_ld_avail && bus.alu_wb_valid && (r_starve_cnt != STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Scoreboard next value: clear the retiring load first so a new load to
    // the same register in the same cycle leaves it pending.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_fifo_pop)  w_pending_nxt = w_pending_nxt & ~reg_onehot(w_head);
        if (w_fifo_push) w_pending_nxt = w_pending_nxt | reg_onehot(bus.issue_dest);
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) r_pending <= '0;
        else       r_pending <= w_pending_nxt;
    end

    a_no_return_when_empty: assert property (
        @(posedge clk) disable iff (reset) !(bus.ld_valid && w_fifo_empty)
    );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
    import regfile_pkg::*;

    localparam int MAX_LOADS    = 4;
    localparam int STARVE_LIMIT = 3;
`ifdef WB_LOAD_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.MAX_LOADS(MAX_LOADS)) bus ();

    regfile_wb_scheduler #(.MAX_LOADS(MAX_LOADS), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int iv, rs, rt, dst, ld, av, aa;
        int unsigned ad;
        int lv;
        int unsigned ldd;
        int es, eh, er, ee, ea;
        int unsigned ed;
        int ep;
    } vec_t;

    vec_t vecs[$];

    // reference model state: outstanding load destinations in issue order
    int q[$];
    int starve;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input int iv, input int rs, input int rt, input int dst, input int ld,
                         input int av, input int aa, input int unsigned ad,
                         input int lv, input int unsigned ldd);
        bus.issue_valid   = iv[0];
        bus.issue_rs      = rs[4:0];
        bus.issue_rt      = rt[4:0];
        bus.issue_dest    = dst[4:0];
        bus.issue_is_load = ld[0];
        bus.alu_wb_valid  = av[0];
        bus.alu_wb_addr   = aa[4:0];
        bus.alu_wb_data   = ad;
        bus.ld_valid      = lv[0];
        bus.ld_data       = ldd;
    endtask

    task automatic tick(input int iv, input int rs, input int rt, input int dst, input int ld,
                        input int av, input int aa, input int unsigned ad,
                        input int lv, input int unsigned ldd);
        @(negedge clk);
        apply(iv, rs, rt, dst, ld, av, aa, ad, lv, ldd);
        #1;
    endtask

    task automatic expect_out(input string tag, input int es, input int eh, input int er,
                              input int ee, input int ea, input int unsigned ed, input int ep);
        check({tag, ".stall"},   bus.issue_stall, es[0]);
        check({tag, ".hold"},    bus.alu_hold,    eh[0]);
        check({tag, ".ready"},   bus.ld_ready,    er[0]);
        check({tag, ".wr_en"},   bus.wr_enable_c, ee[0]);
        check({tag, ".pending"}, bus.loads_pending, ep);
        if (ee != 0) begin
            check({tag, ".wr_addr"}, bus.wr_addr_c, ea);
            check({tag, ".wr_data"}, bus.wr_data_c, ed);
        end
    endtask

    // Reset with live-looking requests present: every output must read 0.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        apply(1, 10, 11, 12, 1, 1, 3, 32'h1234, 0, 0);
        #1;
        expect_out(tag, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        q.delete();
        starve = 0;
    endtask

    function automatic bit is_pend(input int r, input int skip);
        if (r == 0) return 1'b0;
        for (int k = skip; k < q.size(); k++) if (q[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int exp_order[4];
        reset = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        starve = 0;
        do_reset("reset0");

        // iv rs rt dst ld | av aa ad | lv ldd | stall hold rdy en addr data pend
        vecs.push_back('{1, 1, 2, 5, 1,  0, 0, 0,        0, 0,        0, 0, 0, 0, 0, 0,        0});
        vecs.push_back('{1, 5, 0, 6, 0,  0, 0, 0,        0, 0,        1, 0, 0, 0, 0, 0,        1});
        vecs.push_back('{1, 5, 0, 6, 0,  0, 0, 0,        0, 0,        1, 0, 0, 0, 0, 0,        1});
        vecs.push_back('{1, 5, 0, 6, 0,  0, 0, 0,        1, 32'h55,   1-BYP, 0, 1, 1, 5, 32'h55, 1});
        vecs.push_back('{1, 5, 0, 6, 0,  0, 0, 0,        0, 0,        0, 0, 0, 0, 0, 0,        0});
        vecs.push_back('{0, 0, 0, 0, 0,  0, 0, 0,        0, 0,        0, 0, 0, 0, 0, 0,        0});
        vecs.push_back('{1, 0, 0, 7, 1,  0, 0, 0,        0, 0,        0, 0, 0, 0, 0, 0,        0});
        vecs.push_back('{0, 0, 0, 0, 0,  1, 3, 32'h333,  1, 32'h777,  0, 0, 0, 1, 3, 32'h333,  1});
        vecs.push_back('{0, 0, 0, 0, 0,  1, 3, 32'h333,  1, 32'h777,  0, 0, 0, 1, 3, 32'h333,  1});
        vecs.push_back('{0, 0, 0, 0, 0,  1, 3, 32'h333,  1, 32'h777,  0, 0, 0, 1, 3, 32'h333,  1});
        vecs.push_back('{0, 0, 0, 0, 0,  1, 3, 32'h333,  1, 32'h777,  0, 1, 1, 1, 7, 32'h777,  1});
        vecs.push_back('{0, 0, 0, 0, 0,  1, 3, 32'h333,  0, 0,        0, 0, 0, 1, 3, 32'h333,  0});
        vecs.push_back('{0, 0, 0, 0, 0,  1, 0, 32'h444,  0, 0,        0, 0, 0, 0, 0, 0,        0});
        vecs.push_back('{1, 0, 0, 12, 1, 0, 0, 0,        0, 0,        0, 0, 0, 0, 0, 0,        0});
        vecs.push_back('{1, 1, 12, 13, 0, 0, 0, 0,       0, 0,        1, 0, 0, 0, 0, 0,        1});
        vecs.push_back('{1, 0, 0, 12, 0, 0, 0, 0,        0, 0,        1, 0, 0, 0, 0, 0,        1});
        vecs.push_back('{1, 0, 0, 12, 0, 0, 0, 0,        1, 32'hCC,   1-BYP, 0, 1, 1, 12, 32'hCC, 1});
        vecs.push_back('{1, 0, 0, 12, 0, 0, 0, 0,        0, 0,        0, 0, 0, 0, 0, 0,        0});

        foreach (vecs[i]) begin
            tick(vecs[i].iv, vecs[i].rs, vecs[i].rt, vecs[i].dst, vecs[i].ld,
                 vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].ldd);
            expect_out($sformatf("vec%0d", i), vecs[i].es, vecs[i].eh, vecs[i].er,
                       vecs[i].ee, vecs[i].ea, vecs[i].ed, vecs[i].ep);
        end

        // FIFO full: four loads fill it, the fifth stalls until a return.
        do_reset("reset1");
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0, i + 1, 1, 0, 0, 0, 0, 0);
            expect_out($sformatf("fill%0d", i), 0, 0, 0, 0, 0, 0, i);
        end
        tick(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
        expect_out("full_stall", 1, 0, 0, 0, 0, 0, 4);
        tick(1, 0, 0, 8, 1, 0, 0, 0, 1, 32'hA1);
        expect_out("full_pop", 1 - BYP, 0, 1, 1, 1, 32'hA1, 4);
`ifndef WB_LOAD_BYPASS_EN
        tick(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
        expect_out("full_release", 0, 0, 0, 0, 0, 0, 3);
`endif
        exp_order = '{2, 3, 4, 8};
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB0 + i);
            expect_out($sformatf("drain%0d", i), 0, 0, 1, 1, exp_order[i], 32'hB0 + i, 4 - i);
        end

        // Load to $0: handshake completes, write suppressed.
        tick(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        expect_out("r0_issue", 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        expect_out("r0_return", 0, 0, 1, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("r0_after", 0, 0, 0, 0, 0, 0, 0);

        // WAW: second load to $9 waits for the first to retire.
        tick(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        expect_out("waw_first", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
            expect_out($sformatf("waw_stall%0d", i), 1, 0, 0, 0, 0, 0, 1);
        end
        tick(1, 0, 0, 9, 1, 0, 0, 0, 1, 32'h99);
        expect_out("waw_retire", 1 - BYP, 0, 1, 1, 9, 32'h99, 1);
`ifndef WB_LOAD_BYPASS_EN
        tick(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        expect_out("waw_issue", 0, 0, 0, 0, 0, 0, 0);
`endif
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h9A);
        expect_out("waw_second", 0, 0, 1, 1, 9, 32'h9A, 1);

        // Reset with two loads pending clears the scoreboard and FIFO.
        tick(1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 11, 1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("pre_reset", 0, 0, 0, 0, 0, 0, 2);
        do_reset("reset_mid");
        tick(1, 10, 11, 12, 0, 0, 0, 0, 0, 0);
        expect_out("post_reset", 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic against the queue-based reference model.
        do_reset("reset2");
        for (int c = 0; c < 1500; c++) begin
            int iv, rs, rt, dst, ld, av, aa, lv, n, head, skip, full, stall, lw, ld_ok, e_en, e_addr;
            int unsigned ad, ldd, e_data;
            iv  = $urandom_range(0, 1);
            rs  = $urandom_range(0, 7);
            rt  = $urandom_range(0, 7);
            dst = $urandom_range(0, 7);
            ld  = $urandom_range(0, 1);
            av  = ($urandom_range(0, 9) < 4) ? 1 : 0;
            aa  = $urandom_range(0, 7);
            ad  = $urandom;
            ldd = $urandom;
            n   = q.size();
            lv  = (n > 0) ? $urandom_range(0, 1) : 0;
            tick(iv, rs, rt, dst, ld, av, aa, ad, lv, ldd);

            ld_ok  = (lv != 0 && n > 0) ? 1 : 0;
            lw     = (ld_ok != 0 && (av == 0 || starve == STARVE_LIMIT)) ? 1 : 0;
            head   = (n > 0) ? q[0] : 0;
            e_en   = 0;
            e_addr = 0;
            e_data = 0;
            if (lw != 0) begin
                e_addr = head; e_data = ldd; e_en = (head != 0) ? 1 : 0;
            end else if (av != 0) begin
                e_addr = aa; e_data = ad; e_en = (aa != 0) ? 1 : 0;
            end
            skip  = BYP * lw;
            full  = ((n - skip) == MAX_LOADS) ? 1 : 0;
            stall = (iv != 0 && (is_pend(rs, skip) || is_pend(rt, skip) ||
                     is_pend(dst, skip) || (ld != 0 && full != 0))) ? 1 : 0;
            expect_out($sformatf("rnd%0d", c), stall, av * lw, lw, e_en, e_addr, e_data, n);

            if (lw != 0) begin
                void'(q.pop_front());
                starve = 0;
            end else if (ld_ok != 0 && av != 0 && starve < STARVE_LIMIT) begin
                starve++;
            end
            if (iv != 0 && ld != 0 && stall == 0) q.push_back(dst);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
